// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with two combinational read ports, one
// synchronous write port and a per-register busy scoreboard. Decode reads
// operands and marks destinations busy on issue; writeback writes data and
// clears the busy bit. Optional write-to-read bypass hides the writeback
// cycle from decode, and register 0 can be hardwired to zero.
module reg_file_sb #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rs1_out,
   output logic [XLEN-1:0] rs2_out,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            reg_write,
   input  logic [AW-1:0]   write_reg,
   input  logic [XLEN-1:0] w_data,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic [AW:0]     busy_count
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;
   logic             wr_en;
   logic             issue_en;

   // Writes and issues targeting a hardwired-zero register 0 are dropped.
   assign wr_en    = reg_write && !(ZERO_REG && (write_reg == '0));
   assign issue_en = issue_valid && !(ZERO_REG && (issue_rd == '0));

   // Register array: async clear, single synchronous write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[write_reg] <= w_data;
      end
   end

   // Next busy vector: writeback clears first, issue sets after so a
   // same-index collision leaves the newer producer outstanding.
   always_comb begin
      busy_d = busy_q;
      if (reg_write) begin
         busy_d[write_reg] = 1'b0;
      end
      if (issue_en) begin
         busy_d[issue_rd] = 1'b1;
      end
   end

   // Popcount of the next busy vector so the count tracks the busy bits.
   always_comb begin
      count_d = '0;
      for (int i = 0; i < NREGS; i++) begin
         count_d = count_d + {{AW{1'b0}}, busy_d[i]};
      end
   end

   // Scoreboard state and registered busy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   assign busy_count = count_q;

   // Read port 1: zero register, then bypass of the in-flight write, then array.
   always_comb begin
      rs1_out  = regs_q[rs1];
      rs1_busy = busy_q[rs1];
      if (ZERO_REG && (rs1 == '0)) begin
         rs1_out  = '0;
         rs1_busy = 1'b0;
      end else if (BYPASS && wr_en && (write_reg == rs1)) begin
         rs1_out  = w_data;
         rs1_busy = 1'b0;
      end
   end

   // Read port 2: same priority as port 1.
   always_comb begin
      rs2_out  = regs_q[rs2];
      rs2_busy = busy_q[rs2];
      if (ZERO_REG && (rs2 == '0)) begin
         rs2_out  = '0;
         rs2_busy = 1'b0;
      end else if (BYPASS && wr_en && (write_reg == rs2)) begin
         rs2_out  = w_data;
         rs2_busy = 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb. Two instances share the stimulus: dut_a uses the
// default configuration (zero register, bypass), dut_b has both disabled.
// A behavioural model pushes expected outputs into a scoreboard queue when
// inputs are driven; they are popped and compared at the next negedge.
module tb_reg_file_sb;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs1, rs2, write_reg, issue_rd;
   logic        reg_write, issue_valid;
   logic [31:0] w_data;

   logic [31:0] a_rs1_out, a_rs2_out, b_rs1_out, b_rs2_out;
   logic        a_rs1_busy, a_rs2_busy, b_rs1_busy, b_rs2_busy;
   logic [5:0]  a_cnt, b_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;
   exp_t q[$];

   // Model state, index 0 = dut_a, index 1 = dut_b.
   logic [31:0] m_regs [2][32];
   logic        m_busy [2][32];
   bit          m_zr   [2] = '{1'b1, 1'b0};
   bit          m_byp  [2] = '{1'b1, 1'b0};

   reg_file_sb dut_a (
      .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
      .rs1_out(a_rs1_out), .rs2_out(a_rs2_out),
      .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
      .reg_write(reg_write), .write_reg(write_reg), .w_data(w_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_count(a_cnt)
   );

   reg_file_sb #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
      .rs1_out(b_rs1_out), .rs2_out(b_rs2_out),
      .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
      .reg_write(reg_write), .write_reg(write_reg), .w_data(w_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .busy_count(b_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input int c, input logic [4:0] idx);
      if (m_zr[c] && idx == 5'd0) return 32'h0;
      if (m_byp[c] && reg_write && write_reg == idx) return w_data;
      return m_regs[c][idx];
   endfunction

   function automatic logic m_hz(input int c, input logic [4:0] idx);
      if (m_zr[c] && idx == 5'd0) return 1'b0;
      if (m_byp[c] && reg_write && write_reg == idx) return 1'b0;
      return m_busy[c][idx];
   endfunction

   function automatic logic [31:0] m_count(input int c);
      logic [31:0] n = 0;
      for (int i = 0; i < 32; i++) n += {31'b0, m_busy[c][i]};
      return n;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++)
         for (int i = 0; i < 32; i++) begin
            m_regs[c][i] = 32'h0;
            m_busy[c][i] = 1'b0;
         end
   endtask

   task automatic model_clock();
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (reg_write && !(m_zr[c] && write_reg == 5'd0))
               m_regs[c][write_reg] = w_data;
            if (reg_write) m_busy[c][write_reg] = 1'b0;
            if (issue_valid && !(m_zr[c] && issue_rd == 5'd0))
               m_busy[c][issue_rd] = 1'b1;
         end
      end
   endtask

   task automatic push_exp();
      string p;
      for (int c = 0; c < 2; c++) begin
         p = (c == 0) ? "a" : "b";
         q.push_back('{{p, "_rs1_out"},  m_read(c, rs1)});
         q.push_back('{{p, "_rs2_out"},  m_read(c, rs2)});
         q.push_back('{{p, "_rs1_busy"}, {31'b0, m_hz(c, rs1)}});
         q.push_back('{{p, "_rs2_busy"}, {31'b0, m_hz(c, rs2)}});
         q.push_back('{{p, "_busy_count"}, m_count(c)});
      end
   endtask

   task automatic check_all();
      logic [31:0] obs [10];
      exp_t e;
      obs[0] = a_rs1_out;           obs[1] = a_rs2_out;
      obs[2] = {31'b0, a_rs1_busy}; obs[3] = {31'b0, a_rs2_busy};
      obs[4] = {26'b0, a_cnt};
      obs[5] = b_rs1_out;           obs[6] = b_rs2_out;
      obs[7] = {31'b0, b_rs1_busy}; obs[8] = {31'b0, b_rs2_busy};
      obs[9] = {26'b0, b_cnt};
      for (int k = 0; k < 10; k++) begin
         if (q.size() == 0) begin
            chk("scoreboard_empty", 32'h1, 32'h0);
         end else begin
            e = q.pop_front();
            chk(e.tag, obs[k], e.v);
         end
      end
   endtask

   // One clock cycle with the currently driven inputs.
   task automatic step();
      push_exp();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic idle();
      reg_write   = 1'b0;
      issue_valid = 1'b0;
   endtask

   // Asynchronous reset pulse entirely between two clock edges.
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      push_exp();
      #1;
      check_all();
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      model_clock();
      #1;
   endtask

   initial begin
      rst_n = 1'b1;
      rs1 = 0; rs2 = 0; write_reg = 0; issue_rd = 0;
      reg_write = 0; issue_valid = 0; w_data = 0;
      #1 rst_n = 1'b0;
      model_reset();
      push_exp();
      #1 check_all();
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Write 5, read it back, then async reset clears it immediately.
      reg_write = 1; write_reg = 5; w_data = 32'hDEADBEEF; rs1 = 5;
      step();
      idle();
      step();
      chk("rs1_5_before_reset", a_rs1_out, 32'hDEADBEEF);
      async_reset();
      chk("rs1_5_after_reset", a_rs1_out, 32'h0);

      // Reset held across an edge discards the pending write and issue.
      reg_write = 1; write_reg = 6; w_data = 32'h0BADF00D;
      issue_valid = 1; issue_rd = 6; rs1 = 6; rs2 = 6;
      #2 rst_n = 1'b0;
      model_reset();
      push_exp();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_clock();
      #1 rst_n = 1'b1;
      idle();
      step();

      // Register 7 and register 0 writes.
      reg_write = 1; write_reg = 7; w_data = 32'h12345678;
      step();
      write_reg = 0; w_data = 32'hFFFFFFFF;
      step();
      idle(); rs1 = 7; rs2 = 0;
      step();
      chk("x0_zero_reg", a_rs2_out, 32'h0);
      chk("x0_no_zero_reg", b_rs2_out, 32'hFFFFFFFF);

      // Bypass: forwarded in dut_a, old value then new value in dut_b.
      reg_write = 1; write_reg = 3; w_data = 32'hA5A5A5A5; rs1 = 3;
      step();
      idle();
      step();

      // Issue then writeback of register 9.
      issue_valid = 1; issue_rd = 9; rs2 = 9;
      step();
      idle();
      step();
      reg_write = 1; write_reg = 9; w_data = 32'h00000099;
      step();
      idle();
      step();

      // Set/clear collision on register 4, then issue to register 0.
      issue_valid = 1; issue_rd = 4; rs1 = 4;
      step();
      reg_write = 1; write_reg = 4; w_data = 32'h44444444;
      step();
      idle();
      step();
      issue_valid = 1; issue_rd = 4;
      step();
      idle(); issue_valid = 1; issue_rd = 0; rs2 = 0;
      step();
      idle();
      step();

      // Saturation: mark 1..31 busy, then 0 as well (only dut_b tracks it).
      async_reset();
      for (int i = 1; i < 32; i++) begin
         issue_valid = 1; issue_rd = 5'(i); rs1 = 5'(i); rs2 = 5'(i - 1);
         step();
      end
      idle();
      step();
      chk("sat_count_a", {26'b0, a_cnt}, 32'd31);
      issue_valid = 1; issue_rd = 0;
      step();
      idle();
      step();
      chk("sat_count_b", {26'b0, b_cnt}, 32'd32);
      async_reset();

      // Random mix of writes, issues and reads.
      for (int i = 0; i < 40; i++) begin
         reg_write   = 1'($urandom_range(1));
         write_reg   = 5'($urandom_range(31));
         w_data      = $urandom;
         issue_valid = 1'($urandom_range(1));
         issue_rd    = 5'($urandom_range(31));
         rs1         = ($urandom_range(3) == 0) ? write_reg : 5'($urandom_range(31));
         rs2         = 5'($urandom_range(31));
         step();
      end
      idle();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
